// File: rtl/iot_event_serializer.sv
// ---------------------------------------------------------------------------
// iot_event_serializer
//
// Front end of the active-IoT-device monitor. Each asynchronous per-device
// "active" line is passed through its own flop synchroniser. The synchronised
// status is compared with the last value reported downstream. A round-robin
// arbiter picks one mismatching device per clock and reports it as a
// one-cycle change pulse, with its direction and its device id.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      1 = events may be issued; 0 = pending changes are held
//   dev_active  raw per-device status (1 = on), asynchronous to clk
//   change      registered one-cycle event strobe
//   on_off      registered event direction (1 = turned on), 0 when idle
//   dev_id      registered id of the reported device, 0 when idle
//   busy        1 while any synchronised status differs from its reported value
// ---------------------------------------------------------------------------
module iot_event_serializer #(
    parameter int N_DEV       = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_DEV-1:0] dev_active,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic             busy
);

    logic [N_DEV-1:0] sync_q [SYNC_STAGES];
    logic [N_DEV-1:0] sync_d [SYNC_STAGES];
    logic [N_DEV-1:0] reported_q, reported_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic             change_q, change_d;
    logic             on_off_q, on_off_d;
    logic [ID_W-1:0]  dev_id_q, dev_id_d;

    logic [N_DEV-1:0] s;
    logic [N_DEV-1:0] pend;
    logic [N_DEV-1:0] grant_oh;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;
    int               scan_idx;

    assign s    = sync_q[SYNC_STAGES-1];
    assign pend = s ^ reported_q;
    assign busy = |pend;

    assign change = change_q;
    assign on_off = on_off_q;
    assign dev_id = dev_id_q;

    // Synchroniser shift: stage 0 samples the raw lines and every later stage
    // copies the one before it. It runs regardless of enable.
    always_comb begin
        sync_d[0] = dev_active;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Round-robin search. The scan starts one past the last granted device and
    // wraps, so the device just served has the lowest priority next time.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 1; k <= N_DEV; k++) begin
            scan_idx = (int'(last_grant_q) + k) % N_DEV;
            if (!grant_valid && (((pend >> scan_idx) & N_DEV'(1)) != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
        grant_oh = N_DEV'(1) << grant_idx;
    end

    // Event generation. The granted device is mismatched, so toggling its
    // reported bit makes it equal to the synchronised status.
    always_comb begin
        reported_d   = reported_q;
        last_grant_d = last_grant_q;
        change_d     = 1'b0;
        on_off_d     = 1'b0;
        dev_id_d     = '0;
        if (enable && grant_valid) begin
            change_d     = 1'b1;
            on_off_d     = |(s & grant_oh);
            dev_id_d     = grant_idx;
            reported_d   = reported_q ^ grant_oh;
            last_grant_d = grant_idx;
        end
    end

    // State registers. The pointer resets to the highest index so that
    // device 0 has first priority out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            reported_q   <= '0;
            last_grant_q <= ID_W'(N_DEV - 1);
            change_q     <= 1'b0;
            on_off_q     <= 1'b0;
            dev_id_q     <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            reported_q   <= reported_d;
            last_grant_q <= last_grant_d;
            change_q     <= change_d;
            on_off_q     <= on_off_d;
            dev_id_q     <= dev_id_d;
        end
    end

endmodule

// File: tb/tb_iot_event_serializer.sv
// ---------------------------------------------------------------------------
// tb_iot_event_serializer
//
// Scoreboard bench for iot_event_serializer. A reference model steps once per
// rising edge: it delays the sampled inputs through a history of snapshots,
// keeps its own record of the reported values, and queues each event it
// expects together with the cycle in which that event must appear. A monitor
// on the falling edge pops the queue and compares it with the DUT outputs.
// Directed scenarios also check event order against fixed constants.
// ---------------------------------------------------------------------------
module tb_iot_event_serializer;

    localparam int N_DEV       = 4;
    localparam int ID_W        = 2;
    localparam int SYNC_STAGES = 2;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [N_DEV-1:0] dev_active;
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic             busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int due;
        int id;
        bit dir;
    } ev_t;

    ev_t exp_q[$];
    int  log_id[$];
    bit  log_dir[$];
    int  log_cyc[$];

    int               cyc = 0;
    bit [N_DEV-1:0]   hist [SYNC_STAGES];
    bit [N_DEV-1:0]   rep_m;
    bit [N_DEV-1:0]   s_m;
    int               ptr_m;
    bit               found_m;
    int               cand_m;
    bit               exp_busy;
    int               ext_count;
    ev_t              head;

    iot_event_serializer #(
        .N_DEV      (N_DEV),
        .ID_W       (ID_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .dev_active(dev_active),
        .change    (change),
        .on_off    (on_off),
        .dev_id    (dev_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports it if it does not match.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives new inputs (caller sits just after a rising edge) and waits.
    task automatic applyStimulus(input logic [N_DEV-1:0] act, input logic en, input int cycles);
        dev_active = act;
        enable     = en;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear at once.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("reset_change_immediate", int'(change), 0);
        checkOutput("reset_devid_immediate", int'(dev_id), 0);
        checkOutput("reset_onoff_immediate", int'(on_off), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_id.delete();
        log_dir.delete();
        log_cyc.delete();
    endtask

    // Reference model: a device becomes visible SYNC_STAGES edges after its
    // input is sampled; each enabled edge reports the first mismatching
    // device after the last one reported, searching with wrap-around.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                for (int i = 0; i < SYNC_STAGES; i++) hist[i] = '0;
                rep_m    = '0;
                ptr_m    = N_DEV - 1;
                exp_busy = 1'b0;
            end else begin
                s_m     = hist[SYNC_STAGES-1];
                found_m = 1'b0;
                if (enable) begin
                    for (int k = 1; k <= N_DEV; k++) begin
                        cand_m = (ptr_m + k) % N_DEV;
                        if (!found_m && (s_m[cand_m] != rep_m[cand_m])) begin
                            found_m = 1'b1;
                            exp_q.push_back('{cyc, cand_m, s_m[cand_m]});
                            rep_m[cand_m] = s_m[cand_m];
                            ptr_m = cand_m;
                        end
                    end
                end
                for (int i = SYNC_STAGES - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0]  = dev_active;
                exp_busy = |(hist[SYNC_STAGES-1] ^ rep_m);
            end
        end
    end

    // Monitor: compares the DUT with the scoreboard every falling edge and
    // keeps the downstream up/down counter.
    initial begin
        ext_count = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                ext_count = 0;
                checkOutput("reset_change", int'(change), 0);
                checkOutput("reset_devid", int'(dev_id), 0);
                checkOutput("reset_onoff", int'(on_off), 0);
                checkOutput("reset_busy", int'(busy), 0);
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    head = exp_q.pop_front();
                    checkOutput("event_change", int'(change), 1);
                    checkOutput("event_devid", int'(dev_id), head.id);
                    checkOutput("event_onoff", int'(on_off), int'(head.dir));
                    if (change === 1'b1) begin
                        ext_count += (on_off === 1'b1) ? 1 : -1;
                        log_id.push_back(int'(dev_id));
                        log_dir.push_back(on_off);
                        log_cyc.push_back(cyc);
                    end
                end else begin
                    checkOutput("idle_change", int'(change), 0);
                    checkOutput("idle_devid", int'(dev_id), 0);
                    checkOutput("idle_onoff", int'(on_off), 0);
                end
                checkOutput("busy", int'(busy), int'(exp_busy));
                checkOutput("counter_vs_reported", ext_count, $countones(rep_m));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [N_DEV-1:0] nxt;
    logic             en_r;
    logic [31:0]      r;

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        dev_active = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        $display("[TB] idle after reset");
        applyStimulus(4'b0000, 1'b1, 20);
        checkOutput("idle_event_count", log_id.size(), 0);

        $display("[TB] single device on then off");
        applyStimulus(4'b0100, 1'b1, 6);
        checkOutput("single_on_count", log_id.size(), 1);
        if (log_id.size() >= 1) begin
            checkOutput("single_on_id", log_id[0], 2);
            checkOutput("single_on_dir", int'(log_dir[0]), 1);
        end
        checkOutput("single_on_busy_after", int'(busy), 0);
        applyStimulus(4'b0000, 1'b1, 6);
        checkOutput("single_off_count", log_id.size(), 2);
        if (log_id.size() >= 2) begin
            checkOutput("single_off_id", log_id[1], 2);
            checkOutput("single_off_dir", int'(log_dir[1]), 0);
        end

        $display("[TB] all four devices at once");
        doReset();
        applyStimulus(4'b1111, 1'b1, 10);
        checkOutput("burst_count", log_id.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (log_id.size() > i) begin
                checkOutput("burst_id", log_id[i], i);
                checkOutput("burst_dir", int'(log_dir[i]), 1);
            end
        end
        if (log_cyc.size() == 4) checkOutput("burst_consecutive", log_cyc[3] - log_cyc[0], 3);
        checkOutput("burst_counter", ext_count, 4);

        $display("[TB] wrap-around priority");
        doReset();
        applyStimulus(4'b0010, 1'b1, 6);
        applyStimulus(4'b1011, 1'b1, 6);
        checkOutput("wrap_count", log_id.size(), 3);
        if (log_id.size() >= 3) begin
            checkOutput("wrap_first", log_id[1], 3);
            checkOutput("wrap_second", log_id[2], 0);
        end
        applyStimulus(4'b0011, 1'b1, 6);
        checkOutput("wrap_off_count", log_id.size(), 4);
        if (log_id.size() >= 4) begin
            checkOutput("wrap_off_id", log_id[3], 3);
            checkOutput("wrap_off_dir", int'(log_dir[3]), 0);
        end

        $display("[TB] enable gating");
        doReset();
        applyStimulus(4'b0011, 1'b0, 6);
        checkOutput("gated_count", log_id.size(), 0);
        checkOutput("gated_busy", int'(busy), 1);
        applyStimulus(4'b0011, 1'b1, 4);
        checkOutput("ungated_count", log_id.size(), 2);
        if (log_id.size() >= 2) begin
            checkOutput("ungated_first", log_id[0], 0);
            checkOutput("ungated_second", log_id[1], 1);
            checkOutput("ungated_consecutive", log_cyc[1] - log_cyc[0], 1);
        end

        $display("[TB] net-change cancel and reset mid-burst");
        doReset();
        applyStimulus(4'b0010, 1'b0, 5);
        checkOutput("cancel_busy_pending", int'(busy), 1);
        applyStimulus(4'b0000, 1'b0, 5);
        checkOutput("cancel_busy_clear", int'(busy), 0);
        applyStimulus(4'b0000, 1'b1, 5);
        checkOutput("cancel_count", log_id.size(), 0);
        applyStimulus(4'b1111, 1'b1, 4);
        checkOutput("midburst_change", int'(change), 1);
        doReset();
        applyStimulus(4'b1111, 1'b1, 10);
        checkOutput("reissue_count", log_id.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (log_id.size() > i) checkOutput("reissue_id", log_id[i], i);
        end

        $display("[TB] randomized traffic");
        for (int n = 0; n < 500; n++) begin
            nxt = dev_active;
            r   = $urandom;
            if ($urandom_range(0, 2) == 0) nxt = nxt ^ r[N_DEV-1:0];
            en_r = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 199) == 0) doReset();
            applyStimulus(nxt, en_r, 1);
        end
        applyStimulus(dev_active, 1'b1, 10);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iot_event_serializer.md
Name: iot_event_serializer

Overview:
- Front end of the active-IoT-device monitor. Watches N per-device "active" status lines, which are asynchronous to clk.
- Synchronises the lines, finds each device whose status differs from the last value reported downstream, and emits at most one event per clock.
- Each event is a one-cycle change pulse plus an on_off direction and a device id. The change/on_off pair drives the up/down active-device counter directly.
- Round-robin arbitration means simultaneous transitions are all reported and no device starves.

Parameters:
- N_DEV, 4, number of monitored devices; range 2..16.
- ID_W, 2, width of dev_id; must satisfy 2**ID_W >= N_DEV.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; minimum 2.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = arbitration allowed; 0 = no events issued, pending changes are kept.
- dev_active  input  N_DEV  raw status per device; 1 = device on; asynchronous to clk.
- change  output  1  registered one-cycle pulse, 1 = event valid this cycle.
- on_off  output  1  registered event direction: 1 = device turned on, 0 = device turned off; 0 when change=0.
- dev_id  output  ID_W  registered index of the device reported; 0 when change=0.
- busy  output  1  combinational from registers: 1 when any synchronised status differs from the reported status.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync chains, reported[N_DEV-1:0], change, on_off and dev_id are all cleared to 0.
  - Round-robin pointer last_grant = N_DEV-1, so device 0 has first priority.
  - Reset has immediate effect mid-operation; any pending events are discarded.
- Synchroniser:
  - One SYNC_STAGES-deep flop chain per bit.
  - s[i] is the last stage; it always runs, regardless of enable.
- Pending condition: pend[i] = s[i] XOR reported[i].
- busy = OR of pend.
- Arbitration (combinational; registered results):
  - Search starts at index (last_grant+1) mod N_DEV and increases with wrap.
  - The first i with pend[i]=1 wins.
- On each rising edge with enable=1 and a winner g:
  - change <= 1, on_off <= s[g], dev_id <= g.
  - reported[g] <= s[g]; last_grant <= g.
- On each rising edge with enable=0 or no winner:
  - change <= 0, on_off <= 0, dev_id <= 0.
  - reported and last_grant hold.
- Latency: a dev_active level that is stable before rising edge k produces change=1 after edge k+SYNC_STAGES when uncontested. That is SYNC_STAGES+1 edges, i.e. 3 with the default.
- Throughput: one event per cycle maximum. M simultaneous pending devices produce M consecutive change pulses in round-robin order.
- Net-change semantics:
  - A device that toggles on then off before it is granted produces no event, because s and reported match again.
  - Pulses shorter than one clock may be missed; this is acceptable.
  - The downstream counter therefore always equals popcount(reported). It never goes negative or exceeds N_DEV in steady state.
- No overflow is possible: state is one reported bit per device, not a queue.
- Devices already high when reset releases are reported as on events after synchronisation.
- A status change on the granted device in the same cycle as its grant is seen as a new mismatch on the next cycle.

Test Plan:
- Reset with dev_active=4'b0000, release rst_n, hold 20 cycles -> change=0, dev_id=0, on_off=0 and busy=0 throughout.
- dev_active 0000->0100, stable before edge k -> after edge k+2: change=1, on_off=1, dev_id=2 for exactly one cycle; busy=0 afterwards. Then 0100->0000 -> one pulse with change=1, on_off=0, dev_id=2.
- Fresh reset, then dev_active 0000->1111 in one step -> four consecutive pulses with on_off=1 and dev_id=0,1,2,3. The external counter model reaches 4.
- With last_grant=1, devices 0 and 3 both go high in the same step -> dev_id order is 3 then 0 (wrap-around). Then device 3 goes low while device 0 stays high -> a single off event with dev_id=3.
- enable=0 while dev_active goes 0000->0011 -> no change pulses and busy=1. Set enable=1 -> events for dev_id=0 then 1 on consecutive cycles.
- Device 1 is pending with enable=0, device 1 returns low before enable=1 -> no event and busy=0. Then assert rst_n=0 mid-burst of 4 events -> outputs clear immediately. With dev_active still 1111 after release, all four on events are re-issued.
